// File: rtl/ad7606_pkg.sv
// ad7606_pkg: shared state encoding, channel count, OS codes and
// default timing for the AD7606 parallel-mode host controller.
package ad7606_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_HI,
    WAIT_LO,
    RD_LO,
    RD_HI,
    ABORT
  } state_t;

  localparam int NCHAN = 8;

  localparam logic [2:0] OS_NONE = 3'b000;
  localparam logic [2:0] OS_X2   = 3'b001;
  localparam logic [2:0] OS_X4   = 3'b010;
  localparam logic [2:0] OS_X8   = 3'b011;
  localparam logic [2:0] OS_X16  = 3'b100;
  localparam logic [2:0] OS_X32  = 3'b101;
  localparam logic [2:0] OS_X64  = 3'b110;

  localparam int CONVST_LO_DEF = 4;
  localparam int RD_LO_DEF     = 3;
  localparam int RD_HI_DEF     = 2;
  localparam int BUSY_TO_DEF   = 40000;

endpackage

// File: rtl/ad7606_ctrl_sync2.sv
// sync2: generic two-flop synchronizer for asynchronous inputs.
// Resets to zero.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

  assign q_o = r_s2;

endmodule

// File: rtl/ad7606_ctrl.sv
// ad7606_ctrl: AD7606 parallel-mode host controller (CONVST/BUSY/CS/RD).
// Define AD7606_CTRL_FRSTDATA_CHK_EN to flag frames with FRSTDATA errors.
module ad7606_ctrl
  import ad7606_pkg::*;
#(
  parameter int CONVST_LO_CYC = CONVST_LO_DEF,
  parameter int RD_LO_CYC     = RD_LO_DEF,
  parameter int RD_HI_CYC     = RD_HI_DEF,
  parameter int BUSY_TO_CYC   = BUSY_TO_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  os_cfg_i,
  output logic [2:0]  os_o,
  output logic        convst_o,
  output logic        cs_o,
  output logic        rd_o,
  input  logic        busy_i,
  input  logic        frstdata_i,
  input  logic [15:0] db_i,
  output logic [15:0] data_o,
  output logic [2:0]  chan_o,
  output logic        valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic        idle_o
);

  logic        w_busy_s;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt;
  logic [2:0]  r_chan, w_chan;
  logic        r_cap, w_cap;
  logic        r_ferr, w_ferr;
  logic        r_convst, w_convst;
  logic        r_cs, w_cs;
  logic        r_rd, w_rd;
  logic [2:0]  r_os, w_os;
  logic [15:0] r_data, w_data;
  logic [2:0]  r_chan_o, w_chan_o;
  logic        r_valid;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic        w_conv_end, w_lo_end;
  logic        w_hi_end, w_to, w_last;

  sync2 #(.W(1)) u_busy_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (busy_i),
    .q_o     (w_busy_s)
  );

  assign w_conv_end = r_cnt == 32'(CONVST_LO_CYC - 1);
  assign w_lo_end   = r_cnt == 32'(RD_LO_CYC - 1);
  assign w_hi_end   = r_cnt == 32'(RD_HI_CYC - 1);
  assign w_to       = r_cnt == 32'(BUSY_TO_CYC - 1);
  assign w_last     = r_chan == 3'(NCHAN - 1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_chan   <= '0;
      r_cap    <= 1'b0;
      r_ferr   <= 1'b0;
      r_convst <= 1'b1;
      r_cs     <= 1'b1;
      r_rd     <= 1'b1;
      r_os     <= OS_NONE;
      r_data   <= '0;
      r_chan_o <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // cleared on every state entry, saturates otherwise
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 32'd1;
      r_chan   <= w_chan;
      r_cap    <= w_cap;
      r_ferr   <= w_ferr;
      r_convst <= w_convst;
      r_cs     <= w_cs;
      r_rd     <= w_rd;
      r_os     <= w_os;
      r_data   <= w_data;
      r_chan_o <= w_chan_o;
      r_valid  <= r_cap;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_state_nxt = CONV;
      CONV:    if (w_conv_end) w_state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (w_busy_s) w_state_nxt = WAIT_LO;
        else if (w_to) w_state_nxt = ABORT;
      end
      WAIT_LO: begin
        if (!w_busy_s) w_state_nxt = RD_LO;
        else if (w_to) w_state_nxt = ABORT;
      end
      RD_LO:   if (w_lo_end) w_state_nxt = RD_HI;
      RD_HI: begin
        if (w_hi_end) w_state_nxt = w_last ? IDLE : RD_LO;
      end
      ABORT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_convst = r_convst;
    w_cs     = r_cs;
    w_rd     = r_rd;
    w_os     = r_os;
    w_data   = r_data;
    w_chan_o = r_chan_o;
    w_chan   = r_chan;
    w_ferr   = r_ferr;
    w_cap    = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_os     = os_cfg_i;
          w_convst = 1'b0;
          w_ferr   = 1'b0;
        end
      end
      CONV: if (w_conv_end) w_convst = 1'b1;
      WAIT_HI: ;
      WAIT_LO: begin
        if (!w_busy_s) begin
          w_cs   = 1'b0;
          w_rd   = 1'b0;
          w_chan = '0;
        end
      end
      RD_LO: begin
        if (w_lo_end) begin
          w_data   = db_i;
          w_chan_o = r_chan;
          w_rd     = 1'b1;
          w_cap    = 1'b1;
`ifdef AD7606_CTRL_FRSTDATA_CHK_EN
          if (frstdata_i != (r_chan == 3'd0))
            w_ferr = 1'b1;
`endif
        end
      end
      RD_HI: begin
        if (w_hi_end) begin
          if (w_last) begin
            w_cs   = 1'b1;
            w_done = !r_ferr;
            w_err  = r_ferr;
          end else begin
            w_chan = r_chan + 3'd1;
            w_rd   = 1'b0;
          end
        end
      end
      ABORT: begin
        w_cs     = 1'b1;
        w_rd     = 1'b1;
        w_convst = 1'b1;
        w_err    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef AD7606_CTRL_FRSTDATA_CHK_EN
`else
  logic w_unused_fd;
  assign w_unused_fd = frstdata_i;
`endif

  assign os_o     = r_os;
  assign convst_o = r_convst;
  assign cs_o     = r_cs;
  assign rd_o     = r_rd;
  assign data_o   = r_data;
  assign chan_o   = r_chan_o;
  assign valid_o  = r_valid;
  assign done_o   = r_done;
  assign err_o    = r_err;
  assign idle_o   = r_state == IDLE;

endmodule

// File: tb/tb_ad7606_ctrl.sv
// tb_ad7606_ctrl: randomized bench with an AD7606 device model
// and a frame-level scoreboard for ad7606_ctrl.
module tb_ad7606_ctrl;

  localparam int CONVST_LO = 4;
  localparam int RD_LO     = 3;
  localparam int RD_HI     = 2;
  localparam int TO        = 12000;
  localparam int NCH       = 8;
  localparam int SYNC_LAT  = 2;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  os_cfg_i;
  logic [2:0]  os_o;
  logic        convst_o, cs_o, rd_o;
  logic        busy_i = 1'b0;
  logic        frstdata_i = 1'b0;
  logic [15:0] db_i = 16'h0;
  logic [15:0] data_o;
  logic [2:0]  chan_o;
  logic        valid_o, done_o, err_o, idle_o;

  int checks = 0;
  int failures = 0;

  int cyc = 0, n_done = 0, n_err = 0, n_conv = 0;
  int vcount = 0, lo_cnt = 0, lo_len = 0;
  int conv_rise_cyc = 0, rd_rise_cyc = 0, fall_cyc = 0;
  int done_cyc = 0, err_cyc = 0;
  int rise_at = -1, fall_at = -1, rise_cyc = 0;
  int rd_idx = 0, mode = 0;
  bit cs_seen = 0, rd_seen = 0, force_fd0 = 0, rst_dev = 0;
  logic p_convst = 1'b1, p_rd = 1'b1;
  int v_cyc[$];
  int fcounts[$];
  logic [15:0] words [NCH];

  ad7606_ctrl #(
    .CONVST_LO_CYC (CONVST_LO),
    .RD_LO_CYC     (RD_LO),
    .RD_HI_CYC     (RD_HI),
    .BUSY_TO_CYC   (TO)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .os_cfg_i   (os_cfg_i),
    .os_o       (os_o),
    .convst_o   (convst_o),
    .cs_o       (cs_o),
    .rd_o       (rd_o),
    .busy_i     (busy_i),
    .frstdata_i (frstdata_i),
    .db_i       (db_i),
    .data_o     (data_o),
    .chan_o     (chan_o),
    .valid_o    (valid_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .idle_o     (idle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // device model and scoreboard, all at the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst_dev) begin
      busy_i  = 1'b0;
      rise_at = -1;
      fall_at = -1;
    end
    if (valid_o || done_o || err_o)
      chk("excl", 32'(valid_o) + 32'(done_o) + 32'(err_o), 1);
    if (valid_o) begin
      chk("v_chan", 32'(chan_o), vcount);
      chk("v_data", 32'(data_o), 32'(words[chan_o]));
      v_cyc.push_back(cyc);
      vcount++;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
      fcounts.push_back(vcount);
    end
    if (err_o) begin
      n_err++;
      err_cyc = cyc;
      fcounts.push_back(vcount);
    end
    if (!cs_o) cs_seen = 1;
    if (!rd_o) rd_seen = 1;
    if (convst_o === 1'b0) lo_cnt++;
    if (!reset_i && !p_convst && convst_o) begin
      lo_len = lo_cnt;
      n_conv++;
      conv_rise_cyc = cyc;
      vcount = 0;
      rd_idx = 0;
      for (int i = 0; i < NCH; i++) words[i] = 16'($urandom);
      rise_at = (mode == 1) ? -1 : cyc + int'($urandom_range(1, 3));
      fall_at = (mode == 0) ? rise_at + int'($urandom_range(5, 20)) : -1;
    end
    if (convst_o) lo_cnt = 0;
    if (!p_rd && rd_o) begin
      rd_rise_cyc = cyc;
      db_i = 16'($urandom);
    end
    if (p_rd && !rd_o && !cs_o) begin
      db_i = words[rd_idx % NCH];
      frstdata_i = (rd_idx == 0) && !force_fd0;
      rd_idx++;
    end
    if (cyc == rise_at) begin
      busy_i = 1'b1;
      rise_cyc = cyc;
    end
    if (cyc == fall_at) begin
      busy_i = 1'b0;
      fall_cyc = cyc;
    end
    p_convst = convst_o;
    p_rd = rd_o;
  end

  task automatic pulse_start(input logic [2:0] os);
    @(negedge clk);
    start_i = 1'b1;
    os_cfg_i = os;
    @(negedge clk);
    start_i = 1'b0;
    os_cfg_i = 3'($urandom_range(0, 6));
  endtask

  task automatic wait_end(input int d0, input int e0, input int lim);
    int n = 0;
    while (n_done == d0 && n_err == e0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("end_seen", 32'(n_done != d0 || n_err != e0), 1);
  endtask

  task automatic dev_clear();
    rst_dev = 1;
    @(negedge clk);
    #1 rst_dev = 0;
  endtask

  task automatic run_frame(input logic [2:0] os, input bit exp_err);
    int d0 = n_done;
    int e0 = n_err;
    v_cyc.delete();
    pulse_start(os);
    wait_end(d0, e0, 400);
    chk("os", 32'(os_o), 32'(os));
    chk("convst_lo", lo_len, CONVST_LO);
    chk("n_valid", v_cyc.size(), NCH);
    chk("done", n_done - d0, exp_err ? 0 : 1);
    chk("err", n_err - e0, exp_err ? 1 : 0);
    if (v_cyc.size() == NCH) begin
      chk("lat0", v_cyc[0] - fall_cyc, SYNC_LAT + RD_LO + 2);
      for (int k = 1; k < NCH; k++)
        chk("space", v_cyc[k] - v_cyc[k-1], RD_LO + RD_HI);
    end
    chk("end_lat", (exp_err ? err_cyc : done_cyc) - rd_rise_cyc, RD_HI);
    @(negedge clk);
    chk("idle", 32'(idle_o), 1);
  endtask

  initial begin
    int d0, e0, c0, n, lat;
    reset_i = 1'b1;
    start_i = 1'b0;
    os_cfg_i = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pins", {convst_o, cs_o, rd_o, os_o},
        {3'b111, 3'b000});
    chk("rst_strb", {valid_o, done_o, err_o, idle_o}, 4'b0001);
    chk("rst_data", {data_o, chan_o}, 0);
    reset_i = 1'b0;
    @(negedge clk);

    for (int f = 0; f < 3; f++)
      run_frame(3'($urandom_range(0, 6)), 1'b0);

    // BUSY never rises
    mode = 1;
    cs_seen = 0;
    rd_seen = 0;
    v_cyc.delete();
    d0 = n_done;
    e0 = n_err;
    pulse_start(3'b000);
    wait_end(d0, e0, TO + 200);
    chk("to_hi_err", n_err - e0, 1);
    lat = err_cyc - conv_rise_cyc;
    chk("to_hi_lat", 32'(lat >= TO && lat <= TO + 3), 1);
    chk("to_hi_cs", {cs_seen, rd_seen}, 0);
    chk("to_hi_nv", v_cyc.size() + n_done - d0, 0);

    // BUSY stuck high
    mode = 2;
    v_cyc.delete();
    d0 = n_done;
    e0 = n_err;
    pulse_start(3'b001);
    wait_end(d0, e0, TO + 200);
    chk("to_lo_err", n_err - e0, 1);
    lat = err_cyc - rise_cyc;
    chk("to_lo_lat", 32'(lat >= TO && lat <= TO + 6), 1);
    chk("to_lo_nv", v_cyc.size() + n_done - d0, 0);
    mode = 0;
    dev_clear();

    // reset during word 3
    d0 = n_done;
    e0 = n_err;
    pulse_start(3'b011);
    n = 0;
    while (!(vcount == 3 && rd_o == 1'b0) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_reach", 32'(vcount == 3 && rd_o == 1'b0), 1);
    reset_i = 1'b1;
    #1;
    chk("rst_mid", {cs_o, rd_o, convst_o}, 3'b111);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_nostrb", (n_done - d0) + (n_err - e0), 0);
    reset_i = 1'b0;
    dev_clear();
    run_frame(3'b100, 1'b0);

    // start held high: back-to-back frames
    fcounts.delete();
    d0 = n_done;
    e0 = n_err;
    c0 = n_conv;
    @(negedge clk);
    os_cfg_i = 3'b010;
    start_i = 1'b1;
    n = 0;
    while (n_done - d0 < 3 && n < 1500) begin
      @(negedge clk);
      #1;
      n++;
    end
    start_i = 1'b0;
    n = 0;
    while (!(idle_o && convst_o && n_conv - c0 == n_done - d0)
           && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b2b_frames", 32'(n_done - d0 >= 3), 1);
    chk("b2b_match", n_conv - c0, n_done - d0);
    chk("b2b_err", n_err - e0, 0);
    chk("b2b_os", 32'(os_o), 32'(3'b010));
    foreach (fcounts[i]) chk("b2b_nvalid", fcounts[i], NCH);

`ifdef AD7606_CTRL_FRSTDATA_CHK_EN
    force_fd0 = 1;
    run_frame(3'b000, 1'b1);
    force_fd0 = 0;
    run_frame(3'b101, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
